// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM states, default address, R/W bit position.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_RX_DATA   = 3'd3,
        ST_RX_ACK    = 3'd4,
        ST_TX_DATA   = 3'd5,
        ST_TX_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_e;

    localparam logic [6:0] SLAVE_ADDR_DEFAULT = 7'h42;
    localparam int unsigned RW_BIT = 0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus delay flop; rise/fall strobes compare synced vs delayed value.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic sync1_q, sync2_q, dly_q;
    logic sync1_d, sync2_d, dly_d;

    always_comb begin
        sync1_d = i_async;
        sync2_d = sync1_q;
        dly_d   = sync2_q;
    end

    // Reset to the idle-bus level so no edge is reported coming out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            dly_q   <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            dly_q   <= dly_d;
        end
    end

    assign o_level  = sync2_q;
    assign o_rise_c = sync2_q & ~dly_q;
    assign o_fall_c = ~sync2_q & dly_q;

endmodule

// File: rtl/i2c_slave.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection, byte receive and transmit.
module i2c_slave
    import i2c_pkg::*;
#(
    parameter int unsigned         Data_width = 8,
    parameter int unsigned         Address    = 7,
    parameter logic [Address-1:0]  Slave_addr = SLAVE_ADDR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_slave_sclk,
    inout  wire                   io_slave_sdata,
    input  logic [Data_width-1:0] i_slave_datain,
    output logic [Data_width-1:0] o_slave_dataout,
    output logic                  o_slave_rx_valid,
    output logic                  o_slave_rd_req,
    output logic                  o_slave_busy
);

    localparam int unsigned CNT_W = $clog2(Data_width);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(Data_width - 1);

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_c, stop_c;

    i2c_sync_edge u_scl_sync (
        .clk      (clk),
        .rst      (rst),
        .i_async  (i_slave_sclk),
        .o_level  (scl_level),
        .o_rise_c (scl_rise),
        .o_fall_c (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk      (clk),
        .rst      (rst),
        .i_async  (io_slave_sdata),
        .o_level  (sda_level),
        .o_rise_c (sda_rise),
        .o_fall_c (sda_fall)
    );

    assign start_c = sda_fall & scl_level;
    assign stop_c  = sda_rise & scl_level;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [Data_width-1:0] shift_q, shift_d;
    logic [Data_width-1:0] tx_q, tx_d;
    logic [Data_width-1:0] dataout_q, dataout_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rd_req_q, rd_req_d;
    logic                  busy_q, busy_d;
    logic                  ack_seen_q, ack_seen_d;
    logic [Data_width-1:0] shift_in_c;

    assign shift_in_c = {shift_q[Data_width-2:0], sda_level};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        dataout_d  = dataout_q;
        sda_oe_d   = sda_oe_q;
        rx_valid_d = 1'b0;
        rd_req_d   = 1'b0;
        busy_d     = busy_q;
        ack_seen_d = ack_seen_q;

        case (state_q)
            ST_ADDR: begin
                if (scl_rise) begin
                    shift_d = shift_in_c;
                    if (cnt_q == '0) begin
                        ack_seen_d = 1'b0;
                        if (shift_in_c[Data_width-1 -: Address] == Slave_addr) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                        end else begin
                            state_d  = ST_WAIT_STOP;
                            sda_oe_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_ADDR_ACK: begin
                if (scl_rise) begin
                    ack_seen_d = 1'b1;
                end else if (scl_fall && !ack_seen_q) begin
                    sda_oe_d = 1'b1;
                end else if (scl_fall) begin
                    cnt_d = CNT_LOAD;
                    if (shift_q[RW_BIT]) begin
                        rd_req_d = 1'b1;
                        tx_d     = i_slave_datain;
                        sda_oe_d = ~i_slave_datain[Data_width-1];
                        state_d  = ST_TX_DATA;
                    end else begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RX_DATA;
                    end
                end
            end
            ST_RX_DATA: begin
                if (scl_rise) begin
                    shift_d = shift_in_c;
                    if (cnt_q == '0) begin
                        dataout_d  = shift_in_c;
                        rx_valid_d = 1'b1;
                        ack_seen_d = 1'b0;
                        state_d    = ST_RX_ACK;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_RX_ACK: begin
                if (scl_rise) begin
                    ack_seen_d = 1'b1;
                end else if (scl_fall && !ack_seen_q) begin
                    sda_oe_d = 1'b1;
                end else if (scl_fall) begin
                    sda_oe_d = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_RX_DATA;
                end
            end
            ST_TX_DATA: begin
                // MSB was placed on entry; each fall advances to the next bit.
                if (scl_fall) begin
                    if (cnt_q == '0) begin
                        sda_oe_d   = 1'b0;
                        ack_seen_d = 1'b0;
                        state_d    = ST_TX_ACK;
                    end else begin
                        tx_d     = {tx_q[Data_width-2:0], 1'b0};
                        sda_oe_d = ~tx_q[Data_width-2];
                        cnt_d    = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_TX_ACK: begin
                if (scl_rise) begin
                    if (sda_level) begin
                        state_d = ST_WAIT_STOP;
                    end else begin
                        ack_seen_d = 1'b1;
                    end
                end else if (scl_fall && ack_seen_q) begin
                    rd_req_d = 1'b1;
                    tx_d     = i_slave_datain;
                    sda_oe_d = ~i_slave_datain[Data_width-1];
                    cnt_d    = CNT_LOAD;
                    state_d  = ST_TX_DATA;
                end
            end
            default: ;
        endcase

        // Bus conditions override any edge-driven action in the same cycle.
        if (start_c) begin
            state_d    = ST_ADDR;
            cnt_d      = CNT_LOAD;
            shift_d    = '0;
            sda_oe_d   = 1'b0;
            ack_seen_d = 1'b0;
            rx_valid_d = 1'b0;
            rd_req_d   = 1'b0;
        end else if (stop_c) begin
            state_d    = ST_IDLE;
            cnt_d      = CNT_LOAD;
            sda_oe_d   = 1'b0;
            busy_d     = 1'b0;
            rx_valid_d = 1'b0;
            rd_req_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CNT_LOAD;
            shift_q    <= '0;
            tx_q       <= '0;
            dataout_q  <= '0;
            sda_oe_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            ack_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            dataout_q  <= dataout_d;
            sda_oe_q   <= sda_oe_d;
            rx_valid_q <= rx_valid_d;
            rd_req_q   <= rd_req_d;
            busy_q     <= busy_d;
            ack_seen_q <= ack_seen_d;
        end
    end

    assign io_slave_sdata   = sda_oe_q ? 1'b0 : 1'bz;
    assign o_slave_dataout  = dataout_q;
    assign o_slave_rx_valid = rx_valid_q;
    assign o_slave_rd_req   = rd_req_q;
    assign o_slave_busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: open-drain bench master plus scoreboard of expected rx_valid/rd_req events.
module tb_i2c_slave;

    localparam int H = 10;

    typedef struct packed {
        logic       is_rd;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_pin;
    logic       m_low;
    logic [7:0] datain;
    logic [7:0] dataout;
    logic       rx_valid, rd_req, busy;
    wire        sda_bus;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t exp_q[$];

    assign sda_bus = m_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_slave dut (
        .clk              (clk),
        .rst              (rst),
        .i_slave_sclk     (scl_pin),
        .io_slave_sdata   (sda_bus),
        .i_slave_datain   (datain),
        .o_slave_dataout  (dataout),
        .o_slave_rx_valid (rx_valid),
        .o_slave_rd_req   (rd_req),
        .o_slave_busy     (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_bit(input logic b);
        tick(2); m_low = ~b; tick(H - 2);
        scl_pin = 1'b1; tick(H);
        scl_pin = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        tick(2); m_low = 1'b0; tick(H - 2);
        scl_pin = 1'b1; tick(H / 2);
        b = sda_bus; tick(H - H / 2);
        scl_pin = 1'b0;
    endtask

    task automatic i2c_start();
        if (!scl_pin) begin
            tick(2); m_low = 1'b0; tick(H - 2);
            scl_pin = 1'b1; tick(H);
        end
        m_low = 1'b1; tick(H);
        scl_pin = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(2); m_low = 1'b1; tick(H - 2);
        scl_pin = 1'b1; tick(H);
        m_low = 1'b0; tick(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    // next is presented on datain before the ACK bit so a re-request latches it.
    task automatic read_byte(input logic master_ack, input logic [7:0] next, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        datain = next;
        write_bit(~master_ack);
    endtask

    // Monitor: every rx_valid / rd_req pulse must match the head of the scoreboard.
    logic rxv_prev = 1'b0, rdr_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rx_valid || rd_req) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event: rx_valid=%0b rd_req=%0b with empty scoreboard at %0t",
                         rx_valid, rd_req, $time);
            end else begin
                e = exp_q.pop_front();
                check("event_kind_is_rd", 32'(rd_req), 32'(e.is_rd));
                if (rx_valid) check("rx_dataout", 32'(dataout), 32'(e.data));
                check("pulse_width", 32'(rx_valid ? rxv_prev : rdr_prev), 32'd0);
            end
        end
        rxv_prev = rx_valid;
        rdr_prev = rd_req;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] rd;

        rst = 1'b1; scl_pin = 1'b1; m_low = 1'b0; datain = 8'h00;
        tick(4);
        check("rst_dataout", 32'(dataout), 32'h0);
        check("rst_rx_valid", 32'(rx_valid), 32'h0);
        check("rst_rd_req", 32'(rd_req), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_sda", 32'(sda_bus), 32'h1);
        rst = 1'b0;
        tick(4);

        // Single-byte write of 0xA5
        exp_q.push_back('{is_rd: 1'b0, data: 8'hA5});
        i2c_start();
        write_byte(8'h84, ack); check("wr_addr_ack", 32'(ack), 32'h0);
        check("wr_busy", 32'(busy), 32'h1);
        write_byte(8'hA5, ack); check("wr_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        tick(5);
        check("wr_dataout", 32'(dataout), 32'hA5);
        check("wr_busy_after_stop", 32'(busy), 32'h0);

        // Read 0x3C then 0x96 (master ACKs first, NACKs second)
        datain = 8'h3C;
        exp_q.push_back('{is_rd: 1'b1, data: 8'h00});
        exp_q.push_back('{is_rd: 1'b1, data: 8'h00});
        i2c_start();
        write_byte(8'h85, ack); check("rd_addr_ack", 32'(ack), 32'h0);
        read_byte(1'b1, 8'h96, rd); check("rd_byte0", 32'(rd), 32'h3C);
        read_byte(1'b0, 8'h00, rd); check("rd_byte1", 32'(rd), 32'h96);
        check("rd_busy", 32'(busy), 32'h1);
        i2c_stop();
        tick(5);
        check("rd_busy_after_stop", 32'(busy), 32'h0);

        // Non-matching address 0x10: NACK, no events
        i2c_start();
        write_byte(8'h20, ack); check("bad_addr_nack", 32'(ack), 32'h1);
        check("bad_addr_busy", 32'(busy), 32'h0);
        i2c_stop();
        tick(5);

        // Two-byte write
        exp_q.push_back('{is_rd: 1'b0, data: 8'h01});
        exp_q.push_back('{is_rd: 1'b0, data: 8'hFE});
        i2c_start();
        write_byte(8'h84, ack); check("wr2_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h01, ack); check("wr2_ack0", 32'(ack), 32'h0);
        write_byte(8'hFE, ack); check("wr2_ack1", 32'(ack), 32'h0);
        i2c_stop();
        tick(5);
        check("wr2_dataout", 32'(dataout), 32'hFE);

        // Repeated START mid-byte discards the partial byte
        exp_q.push_back('{is_rd: 1'b0, data: 8'h5A});
        i2c_start();
        write_byte(8'h84, ack); check("rs_addr_ack", 32'(ack), 32'h0);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        i2c_start();
        write_byte(8'h84, ack); check("rs_addr2_ack", 32'(ack), 32'h0);
        write_byte(8'h5A, ack); check("rs_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        tick(5);
        check("rs_dataout", 32'(dataout), 32'h5A);

        // Reset while the target drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 2 ? 1'b1 : (i == 7 ? 1'b1 : 1'b0));
        tick(2); m_low = 1'b0; tick(4);
        check("ack_driven_before_rst", 32'(sda_bus), 32'h0);
        check("busy_before_rst", 32'(busy), 32'h1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_sda", 32'(sda_bus), 32'h1);
        check("rst_mid_busy", 32'(busy), 32'h0);
        check("rst_mid_dataout", 32'(dataout), 32'h0);
        rst = 1'b0;
        tick(2); scl_pin = 1'b1; tick(2 * H);

        exp_q.push_back('{is_rd: 1'b0, data: 8'h77});
        i2c_start();
        write_byte(8'h84, ack); check("post_rst_addr_ack", 32'(ack), 32'h0);
        write_byte(8'h77, ack); check("post_rst_data_ack", 32'(ack), 32'h0);
        i2c_stop();
        tick(20);
        check("post_rst_dataout", 32'(dataout), 32'h77);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
